store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Parametrised successor to the single-entry store-to-load forwarding in the execute stage.
- Holds up to DEPTH committed stores in a FIFO and drains them to the d_cache one per accepted handshake.
- Forwards the youngest matching store's data to a same-word load.
- Signals a load stall when the requested bytes are only partially covered.
- Sits between the execute stage and d_cache.

Parameters:
DEPTH, 4, number of store entries; power of two, min 2
ADDR_W, 32, byte address width
DATA_W, 32, data width; multiple of 8; word = DATA_W/8 bytes

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
st_valid  in  1  store request from execute
st_addr  in  ADDR_W  store byte address; low log2(DATA_W/8) bits ignored
st_data  in  DATA_W  store data, lane-aligned
st_strb  in  DATA_W/8  byte enables
st_ready  out  1  buffer can accept a store this cycle
ld_en  in  1  load lookup request
ld_addr  in  ADDR_W  load byte address
ld_strb  in  DATA_W/8  bytes the load needs
ld_hit  out  1  forwarding valid; ld_data usable
ld_data  out  DATA_W  forwarded word
ld_stall  out  1  partial overlap; load must wait
mem_we  out  1  drain request to d_cache
mem_addr  out  ADDR_W  word-aligned drain address
mem_wdata  out  DATA_W  drain data
mem_strb  out  DATA_W/8  drain byte enables
mem_ready  in  1  d_cache accepts the drain this cycle
empty  out  1  no pending stores (used for fence)

Behaviour:
- Storage: circular FIFO with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap DEPTH-1 -> 0.
- Reset (synchronous, rst=1 at posedge):
  - count, head and tail go to 0; all valid bits are cleared.
  - Outputs: st_ready=1, empty=1, mem_we=0, ld_hit=0, ld_stall=0. ld_data, mem_addr, mem_wdata and mem_strb are all 0.
  - Reset mid-drain discards all pending entries; nothing further is issued.
- Push:
  - st_ready = (count != DEPTH). It is combinational from the registered count.
  - A same-cycle pop does NOT make a full buffer accept a push.
  - Push occurs when st_valid && st_ready; the entry is written at tail and tail increments.
  - st_valid with st_ready=0 is dropped by this block; execute must hold the request.
- Drain:
  - mem_we = !empty. mem_addr, mem_wdata and mem_strb come from the head entry, with the low address bits forced to 0.
  - Pop occurs when mem_we && mem_ready; head increments.
  - A pushed entry can be drained no earlier than the cycle after the push.
- Simultaneous push and pop: count is unchanged. This is legal at any count except full, where only the pop occurs.
- Load lookup (combinational, ld_en=1):
  - Lookup covers only entries valid at the start of the cycle. Same-cycle pushes are not visible.
  - An entry being popped this cycle is still visible.
  - Match = same word address (addr[ADDR_W-1:log2(DATA_W/8)]).
  - Select the youngest matching entry, searching from tail-1 back to head.
  - If (youngest.strb & ld_strb) == ld_strb: ld_hit=1 and ld_data=youngest.data; bytes not enabled in strb are 0.
  - Else if any entry matches: ld_stall=1, ld_hit=0.
  - Else: ld_hit=0, ld_stall=0, and the load reads d_cache.
  - With ld_en=0, ld_hit=0, ld_stall=0 and ld_data=0.
- No merging of stores: each store occupies its own entry, including repeated stores to the same word.
- empty = (count == 0). It is registered-state derived.

Test Plan:
- Reset, then push addr 0x100, data 0xDEADBEEF, strb 0xF with mem_ready=0 -> next cycle mem_we=1, mem_addr=0x100, empty=0. Load ld_addr=0x102, strb 0xF -> ld_hit=1, ld_data=0xDEADBEEF.
- With mem_ready=0, push 4 stores to 0x0, 0x4, 0x8, 0xC -> st_ready=0 after the 4th. A 5th st_valid is not accepted even with mem_ready=1 that cycle. Then drain with mem_ready=1 -> mem_addr sequence 0x0, 0x4, 0x8, 0xC, then empty=1.
- Push 0x200/0x11111111 followed by 0x200/0x22222222 -> load 0x200 returns 0x22222222 (youngest wins).
- Push 0x300, data 0x000000AB, strb 0x1; load 0x300 with strb 0x1 -> ld_hit=1, ld_data=0x000000AB. Load 0x300 with strb 0xF -> ld_stall=1, ld_hit=0.
- At count=1 with st_valid=1 and mem_ready=1 for 10 cycles -> count stays 1 and mem_addr follows the push order. Pointer wrap past DEPTH-1 is exercised.
- Assert rst while count=3 and mem_we=1 -> next cycle empty=1, mem_we=0, st_ready=1. Load 0x0 -> ld_hit=0.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer between execute and d_cache: a circular FIFO of committed
// stores that drains one entry per mem_ready handshake and forwards the
// youngest same-word store to loads, stalling on partial byte coverage.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                st_valid,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [DATA_W/8-1:0] st_strb,
  output logic                st_ready,
  input  logic                ld_en,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W/8-1:0] ld_strb,
  output logic                ld_hit,
  output logic [DATA_W-1:0]   ld_data,
  output logic                ld_stall,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_strb,
  input  logic                mem_ready,
  output logic                empty
);

  localparam int NB  = DATA_W / 8;
  localparam int PW  = $clog2(DEPTH);
  localparam int OFF = $clog2(NB);
  localparam logic [PW:0]       FULL_CNT   = (PW+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [NB-1:0]     strb_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [PW:0]       count_q, count_d;

  logic push, pop;

  // Expand byte enables to a bit mask over the data word.
  function automatic logic [DATA_W-1:0] strb_mask(input logic [NB-1:0] s);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < NB; b++) m[b*8 +: 8] = {8{s[b]}};
    return m;
  endfunction

  // Handshakes and status, all derived from registered occupancy.
  always_comb begin
    st_ready  = (count_q != FULL_CNT);
    empty     = (count_q == '0);
    mem_we    = !empty;
    push      = st_valid && st_ready;
    pop       = mem_we && mem_ready;
    mem_addr  = empty ? '0 : addr_q[head_q];
    mem_wdata = empty ? '0 : data_q[head_q];
    mem_strb  = empty ? '0 : strb_q[head_q];
  end

  // Pointer and occupancy next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state: entry write on push, valid clear on pop; reset drops everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        addr_q[tail_q]  <= st_addr & ALIGN_MASK;
        data_q[tail_q]  <= st_data;
        strb_q[tail_q]  <= st_strb;
        valid_q[tail_q] <= 1'b1;
      end
      // head != tail whenever both fire, so these never collide.
      if (pop) valid_q[head_q] <= 1'b0;
    end
  end

  // Forwarding lookup: walk oldest to youngest so the last match wins.
  always_comb begin
    logic              found;
    logic              covered;
    logic [PW-1:0]     idx;
    logic [DATA_W-1:0] sel_data;
    logic [NB-1:0]     sel_strb;
    found    = 1'b0;
    idx      = '0;
    sel_data = '0;
    sel_strb = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && ((ld_addr & ALIGN_MASK) == addr_q[idx])) begin
        found    = 1'b1;
        sel_data = data_q[idx];
        sel_strb = strb_q[idx];
      end
    end
    covered  = ((sel_strb & ld_strb) == ld_strb);
    ld_hit   = ld_en && found && covered;
    ld_stall = ld_en && found && !covered;
    ld_data  = ld_hit ? (sel_data & strb_mask(sel_strb)) : '0;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, 32-bit address/data).
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [3:0]        st_strb;
  logic              st_ready;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [3:0]        ld_strb;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              ld_stall;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_strb;
  logic              mem_ready;
  logic              empty;

  int n_checks = 0;
  int n_errors = 0;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_strb(st_strb),
    .st_ready(st_ready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_strb(ld_strb),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strb(mem_strb),
    .mem_ready(mem_ready), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    st_valid = 1'b1; st_addr = a; st_data = d; st_strb = s;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [3:0] s);
    ld_en = 1'b1; ld_addr = a; ld_strb = s;
    settle();
  endtask

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_strb = '0;
    ld_en = 1'b0; ld_addr = '0; ld_strb = '0; mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    settle();

    // Reset state
    check("rst_st_ready", st_ready, 1);
    check("rst_empty", empty, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_ld_hit", ld_hit, 0);
    check("rst_ld_stall", ld_stall, 0);
    check("rst_ld_data", ld_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_strb", mem_strb, 0);

    // Single push; not drainable or visible in its own cycle
    st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hDEADBEEF; st_strb = 4'hF;
    ld_en = 1'b1; ld_addr = 32'h100; ld_strb = 4'hF;
    settle();
    check("push_cycle_mem_we", mem_we, 0);
    check("push_cycle_ld_hit", ld_hit, 0);
    tick();
    st_valid = 1'b0; ld_en = 1'b0;
    settle();
    check("t1_mem_we", mem_we, 1);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("t1_mem_strb", mem_strb, 4'hF);
    check("t1_empty", empty, 0);
    check("t1_ld_en0_hit", ld_hit, 0);
    check("t1_ld_en0_data", ld_data, 0);
    load(32'h102, 4'hF);
    check("t1_ld_hit", ld_hit, 1);
    check("t1_ld_data", ld_data, 32'hDEADBEEF);
    load(32'h104, 4'hF);
    check("t1_miss_hit", ld_hit, 0);
    check("t1_miss_stall", ld_stall, 0);
    ld_en = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("t1_drained", empty, 1);

    // Fill to DEPTH, full buffer refuses a push even while popping
    push(32'h0, 32'hA0, 4'hF);
    push(32'h4, 32'hA1, 4'hF);
    push(32'h8, 32'hA2, 4'hF);
    check("fill3_st_ready", st_ready, 1);
    push(32'hC, 32'hA3, 4'hF);
    check("full_st_ready", st_ready, 0);
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'h55; st_strb = 4'hF;
    mem_ready = 1'b1;
    settle();
    check("full_pop_st_ready", st_ready, 0);
    check("drain0_addr", mem_addr, 32'h0);
    tick();
    st_valid = 1'b0;
    check("drain1_addr", mem_addr, 32'h4);
    tick();
    check("drain2_addr", mem_addr, 32'h8);
    tick();
    check("drain3_addr", mem_addr, 32'hC);
    check("drain3_wdata", mem_wdata, 32'hA3);
    tick();
    check("full_drop_empty", empty, 1);
    mem_ready = 1'b0;

    // Youngest same-word store wins
    push(32'h200, 32'h11111111, 4'hF);
    push(32'h200, 32'h22222222, 4'hF);
    load(32'h200, 4'hF);
    check("young_hit", ld_hit, 1);
    check("young_data", ld_data, 32'h22222222);
    check("no_merge_head", mem_wdata, 32'h11111111);
    ld_en = 1'b0;
    mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    check("young_drained", empty, 1);

    // Partial coverage: hit on covered bytes (others zeroed), stall otherwise
    push(32'h300, 32'hCCCCCCAB, 4'h1);
    load(32'h300, 4'h1);
    check("part_hit", ld_hit, 1);
    check("part_data", ld_data, 32'h000000AB);
    load(32'h301, 4'hF);
    check("part_stall", ld_stall, 1);
    check("part_stall_hit", ld_hit, 0);
    check("part_stall_data", ld_data, 0);
    load(32'h300, 4'h1);
    mem_ready = 1'b1;
    settle();
    check("popping_visible", ld_hit, 1);
    tick();
    mem_ready = 1'b0;
    settle();
    check("popped_gone_hit", ld_hit, 0);
    check("popped_gone_stall", ld_stall, 0);
    ld_en = 1'b0;

    // Steady push+pop at count=1, wrapping pointers several times
    push(32'h400, 32'h400, 4'hF);
    mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      st_valid = 1'b1; st_addr = 32'h500 + 32'(4*k); st_data = 32'(k); st_strb = 4'hF;
      settle();
      check("steady_st_ready", st_ready, 1);
      check("steady_addr", mem_addr, (k == 0) ? 32'h400 : 32'h500 + 32'(4*(k-1)));
      tick();
    end
    st_valid = 1'b0;
    settle();
    check("steady_count1", empty, 0);
    check("steady_last_addr", mem_addr, 32'h524);
    check("steady_last_data", mem_wdata, 32'h9);
    tick();
    check("steady_empty", empty, 1);
    mem_ready = 1'b0;

    // Reset while draining with three entries pending
    push(32'h0, 32'hB0, 4'hF);
    push(32'h4, 32'hB1, 4'hF);
    push(32'h8, 32'hB2, 4'hF);
    check("pre_rst_mem_we", mem_we, 1);
    mem_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("mid_rst_empty", empty, 1);
    check("mid_rst_mem_we", mem_we, 0);
    check("mid_rst_st_ready", st_ready, 1);
    check("mid_rst_mem_addr", mem_addr, 0);
    load(32'h0, 4'hF);
    check("mid_rst_ld_hit", ld_hit, 0);
    check("mid_rst_ld_stall", ld_stall, 0);
    tick();
    check("post_rst_mem_we", mem_we, 0);
    ld_en = 1'b0;
    mem_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
